pellet_mem_arbiter: RTL and testbench

- Owns the pellet bitmap as a tile-grid single-port RAM and shares it between three users: the VGA renderer (display reads), the game logic (eat read-modify-write) and a level-load sweep (copies an initial pattern from an external ROM).
- Maintains the remaining-pellet count and the all-eaten flag used by the win logic.
- Sits between the pixel/renderer path and the scoring logic. It replaces direct full-array pellet access with one arbitrated RAM port.

---
 rtl/pacman_pkg.sv | 19 +
 rtl/pellet_ram.sv | 20 ++
 rtl/pellet_mem_arbiter.sv | 151 +++++++++++++++
 tb/tb_pellet_mem_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pacman_pkg.sv
// Shared sizes and types for the pellet bitmap and its arbiter.
package pacman_pkg;

  localparam int unsigned COLS    = 27;
  localparam int unsigned ROWS    = 24;
  localparam int unsigned TILE_PX = 16;
  localparam int unsigned N       = COLS * ROWS;
  localparam int unsigned AW      = $clog2(N);
  localparam int unsigned CW      = $clog2(N + 1);

  typedef logic [AW-1:0] tile_addr_t;

  typedef enum logic [2:0] {IDLE, INIT, READY, EAT_RD, EAT_WR} arb_state_t;

  function automatic logic in_range(tile_addr_t a);
    return 32'(a) < N;
  endfunction

endpackage

// File: rtl/pellet_ram.sv
// N x 1 single-port synchronous RAM holding one pellet bit per tile.
module pellet_ram
  import pacman_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  tile_addr_t addr,
  input  logic       wdata,
  output logic       rdata
);

  logic mem [N];

  // Read-first: a write cycle returns the old contents.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/pellet_mem_arbiter.sv
// Shares the pellet RAM between display reads, eat read-modify-writes and the
// level-load sweep; tracks the remaining pellet count.
module pellet_mem_arbiter
  import pacman_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  output logic [AW-1:0] init_rd_addr,
  input  logic          init_rd_data,
  input  logic          disp_req,
  input  logic [AW-1:0] disp_addr,
  output logic          disp_data,
  input  logic          eat_req,
  input  logic [AW-1:0] eat_addr,
  output logic          eat_ack,
  output logic          eat_hit,
  output logic [CW-1:0] pellets_left,
  output logic          ready,
  output logic          all_eaten
);

  localparam logic [CW-1:0] One = CW'(1);

  arb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] left_q, left_d;
  logic          disp_pend_q, disp_pend_d;
  logic          oor_q, oor_d;
  logic          reload_q, reload_d;

  logic       ram_we, ram_wdata, ram_rdata;
  tile_addr_t ram_addr;
  logic       active, disp_go;

  assign active  = (state_q == READY) || (state_q == EAT_RD) || (state_q == EAT_WR);
  assign disp_go = active && disp_req && in_range(disp_addr);

  pellet_ram u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    left_d      = left_q;
    oor_d       = oor_q;
    reload_d    = reload_q;
    disp_pend_d = disp_go;
    ram_we      = 1'b0;
    ram_addr    = '0;
    ram_wdata   = 1'b0;
    eat_ack     = 1'b0;
    eat_hit     = 1'b0;

    if (disp_go) ram_addr = disp_addr;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = INIT;
          cnt_d   = '0;
          left_d  = '0;
        end
      end
      INIT: begin
        // ROM data lags the address by one cycle, so write the previous tile.
        if (cnt_q != '0) begin
          ram_we    = 1'b1;
          ram_addr  = AW'(cnt_q - One);
          ram_wdata = init_rd_data;
          if (init_rd_data) left_d = left_q + One;
        end
        if (cnt_q == CW'(N)) state_d = READY;
        else                 cnt_d   = cnt_q + One;
      end
      READY: begin
        if (start) begin
          state_d = INIT;
          cnt_d   = '0;
          left_d  = '0;
        end else if (eat_req && !disp_req) begin
          state_d = EAT_RD;
          oor_d   = !in_range(eat_addr);
          if (in_range(eat_addr)) ram_addr = eat_addr;
        end
      end
      EAT_RD: begin
        reload_d = reload_q | start;
        if (oor_q || !ram_rdata) eat_ack = 1'b1;
        else                     state_d = EAT_WR;
      end
      EAT_WR: begin
        reload_d = reload_q | start;
        if (!disp_req) begin
          ram_we    = 1'b1;
          ram_addr  = eat_addr;
          ram_wdata = 1'b0;
          eat_ack   = 1'b1;
          eat_hit   = 1'b1;
          left_d    = left_q - One;
        end
      end
      default: state_d = IDLE;
    endcase

    // A reload requested mid-eat starts once the eat has completed.
    if (eat_ack) begin
      if (reload_q || start) begin
        state_d  = INIT;
        cnt_d    = '0;
        left_d   = '0;
        reload_d = 1'b0;
      end else begin
        state_d  = READY;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      left_q      <= '0;
      disp_pend_q <= 1'b0;
      oor_q       <= 1'b0;
      reload_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      left_q      <= left_d;
      disp_pend_q <= disp_pend_d;
      oor_q       <= oor_d;
      reload_q    <= reload_d;
    end
  end

  assign init_rd_addr = (state_q == INIT) ? AW'(cnt_q) : '0;
  assign disp_data    = disp_pend_q & ram_rdata;
  assign pellets_left = left_q;
  assign ready        = active;
  assign all_eaten    = active && (left_q == '0);

  hit_needs_pellet_a: assert property (@(posedge clk) disable iff (!reset)
    (state_q == EAT_WR && !disp_req) |-> (left_q != '0));

endmodule

// File: tb/tb_pellet_mem_arbiter.sv
// Scoreboard bench for pellet_mem_arbiter with a tile-array reference model.
module tb_pellet_mem_arbiter;
  import pacman_pkg::*;

  logic          clk, reset, start, init_rd_data;
  logic          disp_req, disp_data, eat_req, eat_ack, eat_hit, ready, all_eaten;
  logic [AW-1:0] init_rd_addr, disp_addr, eat_addr;
  logic [CW-1:0] pellets_left;

  pellet_mem_arbiter dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .init_rd_addr (init_rd_addr),
    .init_rd_data (init_rd_data),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_data    (disp_data),
    .eat_req      (eat_req),
    .eat_addr     (eat_addr),
    .eat_ack      (eat_ack),
    .eat_hit      (eat_hit),
    .pellets_left (pellets_left),
    .ready        (ready),
    .all_eaten    (all_eaten)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic rom [1 << AW];
  always @(posedge clk) init_rd_data <= rom[init_rd_addr];

  bit mdl [N];
  int mdl_cnt;
  bit active;
  bit disp_q [$];
  bit eat_q [$];
  bit prev_disp;
  int total = 0;
  int bad = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  always @(negedge clk) begin
    if (!reset) begin
      prev_disp = 0;
      disp_q.delete();
      eat_q.delete();
    end else begin
      if (prev_disp) begin
        if (disp_q.size() == 0) check("disp_unexpected", 1, 0);
        else check("disp_data", disp_data, disp_q.pop_front());
      end
      if (eat_ack) begin
        if (eat_q.size() == 0) check("eat_ack_unexpected", 1, 0);
        else check("eat_hit", eat_hit, eat_q.pop_front());
      end
      prev_disp = disp_req;
    end
  end

  task automatic rom_fill(input int mode);
    for (int i = 0; i < (1 << AW); i++) begin
      if (i >= N)         rom[i] = 1'b0;
      else if (mode == 0) rom[i] = 1'b1;
      else if (mode == 1) rom[i] = 1'($urandom_range(0, 1));
      else                rom[i] = (i < 2);
    end
  endtask

  task automatic load_model();
    mdl_cnt = 0;
    for (int i = 0; i < N; i++) begin
      mdl[i] = rom[i];
      if (rom[i]) mdl_cnt++;
    end
  endtask

  // Called one step after the edge that starts INIT.
  task automatic wait_ready(input string name);
    int n;
    n = 0;
    active = 0;
    while (!ready && n < 2000) begin
      start = (n == 100);
      if (n == 200) begin
        disp_req = 1; disp_addr = 5; disp_q.push_back(1'b0);
      end else disp_req = 0;
      @(posedge clk); #1;
      n++;
    end
    start = 0; disp_req = 0;
    check(name, n, N + 1);
    load_model();
    active = 1;
    check("ready_after_load", ready, 1);
    check("pellets_after_load", pellets_left, mdl_cnt);
    check("all_eaten_after_load", all_eaten, mdl_cnt == 0);
  endtask

  task automatic load(input string name);
    start = 1;
    @(posedge clk); #1;
    start = 0;
    wait_ready(name);
  endtask

  task automatic disp_read(input int a);
    bit e;
    e = 0;
    if (active && a < N) e = mdl[a];
    disp_req = 1; disp_addr = AW'(a); disp_q.push_back(e);
    @(posedge clk); #1;
    disp_req = 0;
  endtask

  task automatic eat(input int a, input int stall, input bit reload);
    bit hit;
    int c, ack_at;
    hit = 0;
    if (a < N) hit = mdl[a];
    eat_addr = AW'(a); eat_req = 1; eat_q.push_back(hit);
    c = 0; ack_at = 0;
    while (ack_at == 0 && c < 60) begin
      start = reload && (c == 1);
      if (c >= 2 && c < 2 + stall) begin
        disp_req = 1; disp_addr = AW'(a); disp_q.push_back(hit);
      end else disp_req = 0;
      @(negedge clk);
      c++;
      if (eat_ack) ack_at = c;
      @(posedge clk); #1;
    end
    eat_req = 0; disp_req = 0; start = 0;
    check("eat_latency", ack_at, hit ? 3 + stall : 2);
    if (reload) begin
      wait_ready("reload_latency");
    end else begin
      if (hit) begin
        mdl[a] = 0;
        mdl_cnt--;
      end
      check("pellets_after_eat", pellets_left, mdl_cnt);
      check("all_eaten_after_eat", all_eaten, mdl_cnt == 0);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_ready"}, ready, 0);
    check({tag, "_pellets"}, pellets_left, 0);
    check({tag, "_init_addr"}, init_rd_addr, 0);
    check({tag, "_disp_data"}, disp_data, 0);
    check({tag, "_eat_ack"}, eat_ack, 0);
    check({tag, "_eat_hit"}, eat_hit, 0);
    check({tag, "_all_eaten"}, all_eaten, 0);
  endtask

  initial begin
    int n, a;
    reset = 0; start = 0; disp_req = 0; disp_addr = 0; eat_req = 0; eat_addr = 0;
    active = 0; prev_disp = 0;
    rom_fill(0);
    #1 check_idle_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1;

    // Full level, hit then miss on the same tile.
    load("load_latency");
    check("full_count", pellets_left, N);
    eat(5, 0, 0);
    eat(5, 0, 0);

    // Display collision during EAT_WR, then the cleared tile reads 0.
    eat(10, 4, 0);
    disp_read(10);
    disp_read(11);

    // Out-of-range eat and display.
    eat(700, 0, 0);
    disp_read(900);

    // Reload requested while an eat is in flight.
    rom_fill(1);
    eat(20, 0, 1);

    // Reset during the INIT sweep.
    start = 1;
    @(posedge clk); #1;
    start = 0;
    n = 0;
    while (init_rd_addr != 300 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    check("init_addr_reached", init_rd_addr, 300);
    #2 reset = 0;
    #1 check_idle_outputs("rst_init");
    repeat (2) @(posedge clk);
    #1 reset = 1;
    load("load_after_rst_init");

    // Reset while stalled in EAT_WR.
    a = 0;
    for (int i = N - 1; i >= 0; i--) if (mdl[i]) a = i;
    eat_addr = AW'(a); eat_req = 1; eat_q.push_back(1'b1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    disp_req = 1; disp_addr = AW'(a); disp_q.push_back(1'b1);
    @(posedge clk); #1;
    disp_req = 0; eat_req = 0; reset = 0;
    #1 check_idle_outputs("rst_eat");
    repeat (2) @(posedge clk);
    #1 reset = 1;
    load("load_after_rst_eat");

    // Two-pellet level eaten down to zero.
    rom_fill(2);
    load("load_two");
    eat(0, 0, 0);
    eat(1, 0, 0);
    check("all_eaten_final", all_eaten, 1);

    // Randomised mix of display bursts and eats.
    rom_fill(1);
    load("load_random");
    for (int it = 0; it < 200; it++) begin
      if ($urandom_range(0, 2) == 0) begin
        for (int k = 0; k < int'($urandom_range(1, 3)); k++)
          disp_read(int'($urandom_range(0, (1 << AW) - 1)));
      end else begin
        if ($urandom_range(0, 9) == 0) a = int'($urandom_range(N, (1 << AW) - 1));
        else                           a = int'($urandom_range(0, N - 1));
        eat(a, int'($urandom_range(0, 3)), 0);
      end
    end
    @(posedge clk); #1;
    @(negedge clk);
    check("disp_q_drained", disp_q.size(), 0);
    check("eat_q_drained", eat_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
